// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the two-requester LIFO arbiter
// (stack_arbiter, lifo_store, stack_arbiter_if).
package stack_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arbiter_if.sv
// Request/response bundle between two requester engines and stack_arbiter.
// The arbiter side uses the slave modport; the requester side uses master.
interface stack_arbiter_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic [1:0]   req;
  logic [1:0]   op;
  logic [B-1:0] wdata0;
  logic [B-1:0] wdata1;
  logic [1:0]   gnt;
  logic [1:0]   done;
  logic [B-1:0] rdata;
  logic         err;
  logic         full;
  logic         empty;

  modport master (
    output req, op, wdata0, wdata1,
    input  gnt, done, rdata, err, full, empty
  );

  modport slave (
    input  req, op, wdata0, wdata1,
    output gnt, done, rdata, err, full, empty
  );
endinterface

// File: rtl/stack_arbiter_lifo_store.sv
// lifo_store: stack memory plus occupancy counter with registered full/empty
// and registered pop data. Overflowing pushes and underflowing pops are ignored.
module lifo_store #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [B-1:0] wdata,
  output logic [B-1:0] rdata,
  output logic [W:0]   level,
  output logic         full,
  output logic         empty
);

  localparam logic [W:0] DEPTH = (W+1)'(2**W);

  logic [B-1:0] mem [2**W];
  logic [W:0]   level_nxt;
  logic [W:0]   level_m1;
  logic         do_push;
  logic         do_pop;

  assign do_push  = wr_en & ~full;
  assign do_pop   = rd_en & ~empty;
  assign level_m1 = level - (W+1)'(1);

  always_comb begin
    level_nxt = level;
    if (do_push)
      level_nxt = level + (W+1)'(1);
    else if (do_pop)
      level_nxt = level_m1;
  end

  // Flags are derived from the next level so they line up with the new occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      rdata <= '0;
    end else begin
      level <= level_nxt;
      full  <= (level_nxt == DEPTH);
      empty <= (level_nxt == '0);
      if (rd_en)
        rdata <= do_pop ? mem[level_m1[W-1:0]] : '0;
    end
  end

  // Contents survive reset; only the occupancy counter is cleared
  always_ff @(posedge clk) begin
    if (do_push)
      mem[level[W-1:0]] <= wdata;
  end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin arbitration of two requesters onto one LIFO via an
// IDLE/EXEC/RESP sequencer. Define STACK_ARB_LEVEL_EN to expose the level port.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic clk,
  input  logic reset_n,
`ifdef STACK_ARB_LEVEL_EN
  output logic [W:0] level,
`endif
  stack_arbiter_if.slave bus
);

  state_t       state_p0, state_nxt;
  logic         idx_p1, idx_nxt;
  logic         op_p1, op_nxt;
  logic [B-1:0] wdata_p1, wdata_nxt;
  logic         rr_last, rr_last_nxt;
  logic [1:0]   gnt_p1, gnt_nxt;
  logic [1:0]   done_p2, done_nxt;
  logic         err_p2, err_nxt;
  logic         win;

  logic         wr_en;
  logic         rd_en;
  logic [B-1:0] st_rdata;
  logic [W:0]   st_level;
  logic         st_full;
  logic         st_empty;

  always_comb begin
    state_nxt   = state_p0;
    idx_nxt     = idx_p1;
    op_nxt      = op_p1;
    wdata_nxt   = wdata_p1;
    rr_last_nxt = rr_last;
    gnt_nxt     = 2'b00;
    done_nxt    = 2'b00;
    err_nxt     = 1'b0;
    win         = 1'b0;
    case (state_p0)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          // Contention goes to whoever was not served last
          win       = (bus.req == 2'b11) ? ~rr_last : bus.req[1];
          idx_nxt   = win;
          op_nxt    = bus.op[win];
          wdata_nxt = win ? bus.wdata1 : bus.wdata0;
          gnt_nxt   = win ? 2'b10 : 2'b01;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        done_nxt  = idx_p1 ? 2'b10 : 2'b01;
        err_nxt   = (op_p1 == OP_PUSH) ? st_full : st_empty;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rr_last_nxt = idx_p1;
        state_nxt   = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: request latch in IDLE, grant registered for EXEC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0 <= ST_IDLE;
      idx_p1   <= 1'b0;
      op_p1    <= OP_POP;
      rr_last  <= 1'b1;
      gnt_p1   <= 2'b00;
      done_p2  <= 2'b00;
      err_p2   <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      idx_p1   <= idx_nxt;
      op_p1    <= op_nxt;
      rr_last  <= rr_last_nxt;
      gnt_p1   <= gnt_nxt;
      done_p2  <= done_nxt;
      err_p2   <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    wdata_p1 <= wdata_nxt;
  end

  // Stage p1 -> p2: the store performs the op at the end of EXEC
  assign wr_en = (state_p0 == ST_EXEC) && (op_p1 == OP_PUSH);
  assign rd_en = (state_p0 == ST_EXEC) && (op_p1 == OP_POP);

  lifo_store #(.B(B), .W(W)) u_store (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wdata   (wdata_p1),
    .rdata   (st_rdata),
    .level   (st_level),
    .full    (st_full),
    .empty   (st_empty)
  );

  assign bus.gnt   = gnt_p1;
  assign bus.done  = done_p2;
  assign bus.err   = err_p2;
  assign bus.rdata = ((done_p2 != 2'b00) && (op_p1 == OP_POP)) ? st_rdata : '0;
  assign bus.full  = st_full;
  assign bus.empty = st_empty;

`ifdef STACK_ARB_LEVEL_EN
  assign level = st_level;
`else
  logic unused_level;
  assign unused_level = ^st_level;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomised bench for stack_arbiter against a queue-based stack model with
// round-robin winner selection; level is checked when STACK_ARB_LEVEL_EN is defined.
module tb_stack_arbiter;

  localparam int B = 8;
  localparam int W = 4;
  localparam int DEPTH = 2**W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stack_arbiter_if #(.B(B), .W(W)) bus ();

`ifdef STACK_ARB_LEVEL_EN
  logic [W:0] level;
`endif

  stack_arbiter #(.B(B), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef STACK_ARB_LEVEL_EN
    .level   (level),
`endif
    .bus     (bus)
  );

  logic [B-1:0] stk [$];
  int rr_last = 1;
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    stk.delete();
    rr_last = 1;
  endtask

  task automatic do_reset();
    bus.req = 2'b00; bus.op = 2'b00; bus.wdata0 = '0; bus.wdata1 = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // One arbitration round starting in IDLE (just after a rising edge); inputs held throughout.
  task automatic xact(input logic [1:0] r, input logic [1:0] o,
                      input logic [B-1:0] d0, input logic [B-1:0] d1);
    int win;
    int pre_lvl;
    logic [1:0] exp_oh;
    logic [B-1:0] exp_rd;
    logic exp_err;
    bus.req = r; bus.op = o; bus.wdata0 = d0; bus.wdata1 = d1;
    if (r == 2'b11) win = (rr_last == 1) ? 0 : 1;
    else            win = r[1] ? 1 : 0;
    exp_oh  = (win == 1) ? 2'b10 : 2'b01;
    pre_lvl = stk.size();
    exp_rd  = '0;
    exp_err = 1'b0;
    if (o[win]) begin
      if (stk.size() == DEPTH) exp_err = 1'b1;
      else stk.push_back((win == 1) ? d1 : d0);
    end else begin
      if (stk.size() == 0) exp_err = 1'b1;
      else exp_rd = stk.pop_back();
    end
    rr_last = win;

    @(posedge clk); @(negedge clk);
    vectors++;
    if (bus.gnt !== exp_oh || bus.done !== 2'b00) begin
      miscompares++;
      $display("FAIL exec_gnt: gnt=%b done=%b, expected gnt=%b done=00", bus.gnt, bus.done, exp_oh);
    end
`ifdef STACK_ARB_LEVEL_EN
    vectors++;
    if (level !== (W+1)'(pre_lvl)) begin
      miscompares++;
      $display("FAIL exec_level: got %0d expected %0d", level, pre_lvl);
    end
`endif

    @(posedge clk); @(negedge clk);
    vectors++;
    if (bus.done !== exp_oh || bus.gnt !== 2'b00) begin
      miscompares++;
      $display("FAIL resp_done: done=%b gnt=%b, expected done=%b gnt=00", bus.done, bus.gnt, exp_oh);
    end
    vectors++;
    if (bus.rdata !== exp_rd) begin
      miscompares++;
      $display("FAIL resp_rdata: got %h expected %h", bus.rdata, exp_rd);
    end
    vectors++;
    if (bus.err !== exp_err) begin
      miscompares++;
      $display("FAIL resp_err: got %b expected %b", bus.err, exp_err);
    end
    vectors++;
    if (bus.full !== (stk.size() == DEPTH) || bus.empty !== (stk.size() == 0)) begin
      miscompares++;
      $display("FAIL resp_flags: full=%b empty=%b, model level %0d", bus.full, bus.empty, stk.size());
    end
`ifdef STACK_ARB_LEVEL_EN
    vectors++;
    if (level !== (W+1)'(stk.size())) begin
      miscompares++;
      $display("FAIL resp_level: got %0d expected %0d", level, stk.size());
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.req = 2'b00; bus.op = 2'b00; bus.wdata0 = '0; bus.wdata1 = '0;
    reset_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: empty=%b full=%b, expected 1/0", bus.empty, bus.full);
    end
    vectors++;
    if (bus.done !== 2'b00 || bus.gnt !== 2'b00 || bus.err !== 1'b0 || bus.rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: done=%b gnt=%b err=%b rdata=%h, expected all 0",
               bus.done, bus.gnt, bus.err, bus.rdata);
    end
`ifdef STACK_ARB_LEVEL_EN
    vectors++;
    if (level !== '0) begin
      miscompares++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
`endif
    @(posedge clk); #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    xact(2'b01, 2'b01, 8'hA5, 8'h00);
    xact(2'b01, 2'b00, 8'h00, 8'h00);
    bus.req = 2'b00;
  endtask

  task automatic test_alternate();
    do_reset();
    repeat (4) xact(2'b11, 2'b11, 8'h11, 8'h22);
    repeat (4) xact(2'b11, 2'b00, 8'h00, 8'h00);
    bus.req = 2'b00;
  endtask

  task automatic test_full_empty();
    do_reset();
    for (int i = 0; i < DEPTH; i++) xact(2'b10, 2'b10, 8'h00, B'($urandom));
    xact(2'b10, 2'b10, 8'h00, 8'h5C);
    for (int i = 0; i < DEPTH; i++) xact(2'b01, 2'b00, 8'h00, 8'h00);
    xact(2'b01, 2'b00, 8'h00, 8'h00);
    bus.req = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    bus.req = 2'b01; bus.op = 2'b01; bus.wdata0 = 8'h5A;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (bus.gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_exec: gnt=%b expected 01", bus.gnt);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.gnt !== 2'b00 || bus.done !== 2'b00) begin
      miscompares++;
      $display("FAIL midrst_async: gnt=%b done=%b expected 00/00", bus.gnt, bus.done);
    end
    @(posedge clk); #1;
    bus.req = 2'b00;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.done !== 2'b00 || bus.empty !== 1'b1) begin
        miscompares++;
        $display("FAIL midrst_after: done=%b empty=%b expected 00/1", bus.done, bus.empty);
      end
    end
    @(posedge clk); #1;
    xact(2'b01, 2'b00, 8'h00, 8'h00);
    bus.req = 2'b00;
  endtask

  task automatic test_level();
    do_reset();
    xact(2'b01, 2'b01, 8'h01, 8'h00);
    xact(2'b10, 2'b10, 8'h00, 8'h02);
    xact(2'b01, 2'b01, 8'h03, 8'h00);
    xact(2'b10, 2'b00, 8'h00, 8'h00);
    bus.req = 2'b00;
  endtask

  task automatic test_random();
    int push_pct;
    logic [1:0] r, o;
    do_reset();
    for (int n = 0; n < 160; n++) begin
      push_pct = (n < 80) ? 70 : 30;
      r = 2'($urandom_range(1, 3));
      o[0] = ($urandom_range(0, 99) < push_pct);
      o[1] = ($urandom_range(0, 99) < push_pct);
      xact(r, o, B'($urandom), B'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        bus.req = 2'b00;
        @(negedge clk);
        vectors++;
        if (bus.gnt !== 2'b00 || bus.done !== 2'b00) begin
          miscompares++;
          $display("FAIL idle_quiet: gnt=%b done=%b expected 00/00", bus.gnt, bus.done);
        end
        @(posedge clk); #1;
      end
    end
    bus.req = 2'b00;
  endtask

  initial begin
    bus.req = 2'b00; bus.op = 2'b00; bus.wdata0 = '0; bus.wdata1 = '0;
    test_reset();
    test_basic();
    test_alternate();
    test_full_empty();
    test_reset_mid_op();
    test_level();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
